sram_arbiter: RTL

Two-requester arbiter in front of the single-port synchronous `sram` block. It shares the RAM between the CPU port (read/write) and the video fetch port (read-only) using per-port request/grant handshakes. Video has priority, bounded by a starvation limit that guarantees CPU progress. The block registers read data back to each port with a fixed latency.

---
 rtl/sram_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port synchronous SRAM between a CPU port (read/write)
//   and a video fetch port (read-only). Video wins contention until it has
//   taken STARVE_LIMIT consecutive grants while the CPU waits; the CPU then
//   gets the next slot. Read data returns two cycles after the grant.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata CPU request; held until cpu_gnt
//   cpu_gnt               CPU access issued to SRAM this cycle
//   cpu_rvalid/rdata      one-cycle read-return pulse / held read data
//   vid_req/addr          video read request; held until vid_gnt
//   vid_gnt               video read issued this cycle
//   vid_rvalid/rdata      one-cycle read-return pulse / held read data
//   sram_addr/data_in/we  SRAM command
//   sram_data_out         SRAM read data, valid the cycle after the address
module sram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_data_out
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic              vid_pend_q, vid_pend_d;
  logic              cpu_rvalid_q, vid_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, vid_rdata_q;
  logic              cpu_win;

  // Grant decision. Grants are gated by reset so nothing reaches the SRAM
  // while the block is held in reset.
  always_comb begin
    cpu_win = cpu_req & (~vid_req | (starve_q >= LIMIT));
    cpu_gnt = reset & cpu_win;
    vid_gnt = reset & vid_req & ~cpu_win;
  end

  // Next-state: starvation counter and read-return tags.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_req || cpu_gnt) begin
      starve_d = 4'd0;
    end else if (vid_gnt && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
    // Writes never produce a return, so only CPU reads are tagged.
    cpu_pend_d = cpu_gnt & ~cpu_we;
    vid_pend_d = vid_gnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q     <= 4'd0;
      cpu_pend_q   <= 1'b0;
      vid_pend_q   <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
    end else begin
      starve_q     <= starve_d;
      cpu_pend_q   <= cpu_pend_d;
      vid_pend_q   <= vid_pend_d;
      // The tag is one cycle old here, which is exactly when the SRAM output
      // belongs to that access.
      cpu_rvalid_q <= cpu_pend_q;
      vid_rvalid_q <= vid_pend_q;
      if (cpu_pend_q) cpu_rdata_q <= sram_data_out;
      if (vid_pend_q) vid_rdata_q <= sram_data_out;
    end
  end

  // Outputs. Idle cycles present the video address so a fresh video request
  // needs no extra mux change.
  always_comb begin
    sram_addr    = cpu_gnt ? cpu_addr : vid_addr;
    sram_we      = cpu_gnt & cpu_we;
    sram_data_in = cpu_wdata;
    cpu_rvalid   = cpu_rvalid_q;
    vid_rvalid   = vid_rvalid_q;
    cpu_rdata    = cpu_rdata_q;
    vid_rdata    = vid_rdata_q;
  end

endmodule
